// File: rtl/conv_enc.sv
// conv_enc: rate-1/2, K=7 convolutional encoder (generators 133/171 octal).
// Accepts one data bit per handshake and emits the coded pair serially,
// A then B, one bit per clock. After the bit flagged di_last, TAIL_LEN
// zero bits are fed internally so the trellis ends in the all-zero state.
// Optional build macro CONV_PUNCTURE_EN adds input rate_sel and the
// rate-3/4 puncturing pattern (keep A,B / keep A / keep B per phase).

module conv_enc #(
    parameter logic [6:0] G0       = 7'o133,
    parameter logic [6:0] G1       = 7'o171,
    parameter int         TAIL_LEN = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic di_bit,
    input  logic di_vld,
    input  logic di_last,
`ifdef CONV_PUNCTURE_EN
    input  logic rate_sel,
`endif
    output logic di_rdy,
    output logic do_bit,
    output logic do_vld,
    output logic do_last
);

    localparam int            CW       = $clog2(TAIL_LEN + 1);
    localparam logic [CW-1:0] TAIL_MAX = CW'(TAIL_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_A,
        S_B
    } state_t;

    state_t        r_state;
    state_t        w_nextState;

    // Encoder history, r_sr[5] is the most recent input bit.
    logic [5:0]    r_sr;
    logic          r_a;
    logic          r_b;

    // r_inTail: the pair in flight came from di_last or from a tail zero.
    logic          r_inTail;
    logic [CW-1:0] r_tailCnt;

    logic          w_rdy;
    logic          w_accept;
    logic          w_finalPair;
    logic          w_feedTail;
    logic          w_frameDone;
    logic          w_load;
    logic          w_encIn;
    logic [6:0]    w_v;
    logic          w_a;
    logic          w_b;
    logic          w_keepA;
    logic          w_keepB;

    // Handshake and sequencing terms.
    assign w_rdy       = (r_state == S_IDLE) || ((r_state == S_B) && !r_inTail);
    assign di_rdy      = w_rdy;
    assign w_accept    = di_vld && w_rdy;
    assign w_finalPair = r_inTail && (r_tailCnt == TAIL_MAX);
    assign w_feedTail  = (r_state == S_B) && r_inTail && (r_tailCnt != TAIL_MAX);
    assign w_frameDone = (r_state == S_B) && w_finalPair;
    assign w_load      = w_accept || w_feedTail;

    // Tail feeds never coincide with an accept, because di_rdy is low then.
    assign w_encIn = w_accept ? di_bit : 1'b0;
    assign w_v     = {w_encIn, r_sr};
    assign w_a     = ^(w_v & G0);
    assign w_b     = ^(w_v & G1);

`ifdef CONV_PUNCTURE_EN
    // r_inFrame distinguishes a frame's first bit from a resume after a stall.
    logic       r_inFrame;
    logic       r_rate;
    logic [1:0] r_phase;
    logic       w_frameStart;

    assign w_frameStart = w_accept && !r_inFrame;
    assign w_keepA      = !(r_rate && (r_phase == 2'd2));
    assign w_keepB      = !(r_rate && (r_phase == 2'd1));

    // Latch the rate at frame start and step the puncture phase per pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inFrame <= 1'b0;
            r_rate    <= 1'b0;
            r_phase   <= 2'd0;
        end else begin
            if (w_frameStart) begin
                r_rate  <= rate_sel;
                r_phase <= 2'd0;
            end else if (w_load) begin
                r_phase <= (r_phase == 2'd2) ? 2'd0 : r_phase + 2'd1;
            end
            if (w_accept) begin
                r_inFrame <= 1'b1;
            end else if (w_frameDone) begin
                r_inFrame <= 1'b0;
            end
        end
    end
`else
    assign w_keepA = 1'b1;
    assign w_keepB = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state: each loaded pair takes exactly two cycles, A then B.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_nextState = S_A;
                end
            end
            S_A: begin
                w_nextState = S_B;
            end
            S_B: begin
                if (w_finalPair) begin
                    w_nextState = S_IDLE;
                end else if (w_load) begin
                    w_nextState = S_A;
                end else begin
                    w_nextState = S_IDLE;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Shift register and the registered coded pair, updated on every load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr <= 6'd0;
            r_a  <= 1'b0;
            r_b  <= 1'b0;
        end else if (w_load) begin
            r_sr <= {w_encIn, r_sr[5:1]};
            r_a  <= w_a;
            r_b  <= w_b;
        end
    end

    // Tail bookkeeping: arm on di_last, count fed zeros, clear at frame end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inTail  <= 1'b0;
            r_tailCnt <= '0;
        end else if (w_frameDone) begin
            r_inTail  <= 1'b0;
            r_tailCnt <= '0;
        end else if (w_feedTail) begin
            r_tailCnt <= r_tailCnt + CW'(1);
        end else if (w_accept) begin
            r_inTail  <= di_last;
            r_tailCnt <= '0;
        end
    end

    // Output mux: A in S_A, B in S_B, punctured slots forced to zero.
    always_comb begin
        do_vld  = 1'b0;
        do_bit  = 1'b0;
        do_last = 1'b0;
        case (r_state)
            S_A: begin
                do_vld  = w_keepA;
                do_bit  = w_keepA & r_a;
                do_last = w_keepA && w_finalPair && !w_keepB;
            end
            S_B: begin
                do_vld  = w_keepB;
                do_bit  = w_keepB & r_b;
                do_last = w_keepB && w_finalPair;
            end
            default: begin
                do_vld  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_conv_enc.sv
// tb_conv_enc: directed self-checking bench for conv_enc.
// Covers reset, impulse, all-zero frame, back-to-back frame, stalled frame,
// reset during the tail and, when CONV_PUNCTURE_EN is defined, rate 3/4.

module tb_conv_enc;

    logic clk;
    logic rst;
    logic di_bit;
    logic di_vld;
    logic di_last;
    logic di_rdy;
    logic do_bit;
    logic do_vld;
    logic do_last;
`ifdef CONV_PUNCTURE_EN
    logic rate_sel;
`endif

    int checks   = 0;
    int failures = 0;
    int cycleCnt = 0;

    logic frameBits [0:63];
    logic outBits [$];
    logic outLast [$];
    int   outCyc  [$];
    logic expQ    [$];

    conv_enc dut (
        .clk     (clk),
        .rst     (rst),
        .di_bit  (di_bit),
        .di_vld  (di_vld),
        .di_last (di_last),
`ifdef CONV_PUNCTURE_EN
        .rate_sel(rate_sel),
`endif
        .di_rdy  (di_rdy),
        .do_bit  (do_bit),
        .do_vld  (do_vld),
        .do_last (do_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle index used to time-stamp emitted bits.
    always @(posedge clk) cycleCnt++;

    // Capture every valid coded bit away from the active edge.
    always @(negedge clk) begin
        if (do_vld) begin
            outBits.push_back(do_bit);
            outLast.push_back(do_last);
            outCyc.push_back(cycleCnt);
        end
    end

    task automatic clearMon();
        outBits.delete();
        outLast.delete();
        outCyc.delete();
    endtask

    // Reference encoder written as an explicit tap delay line.
    task automatic buildExpected(input int len);
        bit d [1:6];
        bit inb;
        expQ.delete();
        for (int k = 1; k <= 6; k++) d[k] = 1'b0;
        for (int i = 0; i < len + 6; i++) begin
            inb = (i < len) ? frameBits[i] : 1'b0;
            expQ.push_back(inb ^ d[2] ^ d[3] ^ d[5] ^ d[6]);
            expQ.push_back(inb ^ d[1] ^ d[2] ^ d[3] ^ d[6]);
            for (int k = 6; k > 1; k--) d[k] = d[k-1];
            d[1] = inb;
        end
    endtask

    // Present frameBits[0..len-1]; optional random idle cycles with junk data.
    task automatic sendFrame(input int len, input bit stall);
        int idx   = 0;
        int guard = 0;
        while (idx < len && guard < 3000) begin
            @(negedge clk);
            guard++;
            if (stall && ($urandom_range(0, 2) == 0)) begin
                di_vld  = 1'b0;
                di_bit  = 1'($urandom_range(0, 1));
                di_last = 1'($urandom_range(0, 1));
            end else begin
                di_vld  = 1'b1;
                di_bit  = frameBits[idx];
                di_last = (idx == len - 1);
                if (di_rdy) idx++;
            end
        end
        if (idx < len) begin
            checks++;
            failures++;
            $display("[TB] FAIL send_timeout accepted=%0d required=%0d", idx, len);
        end
        @(negedge clk);
        di_vld  = 1'b0;
        di_last = 1'b0;
        di_bit  = 1'b0;
    endtask

    // Wait (bounded) for do_last; count cycles where di_rdy was high meanwhile.
    task automatic waitFrameEnd(output int rdyHigh, output bit seen);
        rdyHigh = 0;
        seen    = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (di_rdy) rdyHigh++;
            if (do_vld && do_last) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic runImpulse();
        int rh;
        bit seen;
        frameBits[0] = 1'b1;
        sendFrame(1, 1'b0);
        waitFrameEnd(rh, seen);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (do_vld !== 1'b0) begin failures++; $display("[TB] FAIL reset_do_vld got=%b want=0", do_vld); end
        checks++;
        if (do_bit !== 1'b0) begin failures++; $display("[TB] FAIL reset_do_bit got=%b want=0", do_bit); end
        checks++;
        if (do_last !== 1'b0) begin failures++; $display("[TB] FAIL reset_do_last got=%b want=0", do_last); end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (di_rdy !== 1'b1) begin failures++; $display("[TB] FAIL reset_di_rdy got=%b want=1", di_rdy); end
    endtask

    task automatic test_impulse();
        logic [13:0] got;
        logic [13:0] want;
        int rh;
        bit seen;
        want = 14'b11_01_11_11_00_10_11;
        got  = '0;
        clearMon();
        frameBits[0] = 1'b1;
        sendFrame(1, 1'b0);
        waitFrameEnd(rh, seen);
        checks++;
        if (!seen) begin failures++; $display("[TB] FAIL impulse_do_last_seen got=0 want=1"); end
        checks++;
        if (outBits.size() != 14) begin failures++; $display("[TB] FAIL impulse_count got=%0d want=14", outBits.size()); end
        for (int i = 0; i < 14 && i < outBits.size(); i++) got[13-i] = outBits[i];
        checks++;
        if (got !== want) begin failures++; $display("[TB] FAIL impulse_stream got=%b want=%b", got, want); end
        checks++;
        if (outBits.size() == 14 && outLast[13] !== 1'b1) begin
            failures++; $display("[TB] FAIL impulse_last_pos got=%b want=1", outLast[13]);
        end
        checks++;
        if (rh != 0) begin failures++; $display("[TB] FAIL impulse_rdy_in_tail got=%0d want=0", rh); end
        checks++;
        if (di_rdy !== 1'b1) begin failures++; $display("[TB] FAIL impulse_rdy_after got=%b want=1", di_rdy); end
    endtask

    task automatic test_all_zero();
        int rh;
        bit seen;
        int ones = 0;
        int lasts = 0;
        clearMon();
        for (int i = 0; i < 10; i++) frameBits[i] = 1'b0;
        sendFrame(10, 1'b0);
        waitFrameEnd(rh, seen);
        foreach (outBits[i]) begin
            if (outBits[i] !== 1'b0) ones++;
            if (outLast[i] === 1'b1) lasts++;
        end
        checks++;
        if (outBits.size() != 32) begin failures++; $display("[TB] FAIL zero_count got=%0d want=32", outBits.size()); end
        checks++;
        if (ones != 0) begin failures++; $display("[TB] FAIL zero_ones got=%0d want=0", ones); end
        checks++;
        if (lasts != 1 || outLast[outLast.size()-1] !== 1'b1) begin
            failures++; $display("[TB] FAIL zero_last got=%0d want=1 on final bit", lasts);
        end
        checks++;
        if (dut.r_sr !== 6'd0) begin failures++; $display("[TB] FAIL zero_sr got=%b want=000000", dut.r_sr); end
    endtask

    task automatic checkAgainstModel(input string tag, input int wantCnt);
        int mism = 0;
        int lasts = 0;
        int splits = 0;
        checks++;
        if (outBits.size() != wantCnt) begin
            failures++; $display("[TB] FAIL %s_count got=%0d want=%0d", tag, outBits.size(), wantCnt);
        end
        for (int i = 0; i < outBits.size() && i < expQ.size(); i++) begin
            if (outBits[i] !== expQ[i]) mism++;
            if (outLast[i] === 1'b1) lasts++;
        end
        for (int i = 0; i + 1 < outCyc.size(); i += 2) begin
            if (outCyc[i+1] - outCyc[i] != 1) splits++;
        end
        checks++;
        if (mism != 0) begin failures++; $display("[TB] FAIL %s_stream mismatched_bits=%0d want=0", tag, mism); end
        checks++;
        if (lasts != 1 || outLast[outLast.size()-1] !== 1'b1) begin
            failures++; $display("[TB] FAIL %s_last got=%0d want=1 on final bit", tag, lasts);
        end
        checks++;
        if (splits != 0) begin failures++; $display("[TB] FAIL %s_pair_split got=%0d want=0", tag, splits); end
    endtask

    task automatic loadPattern();
        logic [47:0] pat;
        pat = 48'hB5C3_9A1E_74D2;
        for (int i = 0; i < 48; i++) frameBits[i] = pat[i];
    endtask

    task automatic test_back_to_back();
        int rh;
        bit seen;
        int span;
        clearMon();
        loadPattern();
        buildExpected(48);
        sendFrame(48, 1'b0);
        waitFrameEnd(rh, seen);
        checkAgainstModel("b2b", 108);
        span = (outCyc.size() > 0) ? outCyc[outCyc.size()-1] - outCyc[0] + 1 : 0;
        checks++;
        if (span != 108) begin failures++; $display("[TB] FAIL b2b_continuous span=%0d want=108", span); end
    endtask

    task automatic test_stall();
        int rh;
        bit seen;
        clearMon();
        loadPattern();
        buildExpected(48);
        sendFrame(48, 1'b1);
        waitFrameEnd(rh, seen);
        checkAgainstModel("stall", 108);
    endtask

    task automatic test_reset_mid_tail();
        int cnt = 0;
        logic [13:0] got;
        clearMon();
        frameBits[0] = 1'b1;
        sendFrame(1, 1'b0);
        for (int c = 0; c < 40; c++) begin
            if (do_vld) cnt++;
            if (cnt == 7) break;
            @(negedge clk);
        end
        checks++;
        if (cnt != 7) begin failures++; $display("[TB] FAIL rst_reach_pair4 got=%0d want=7", cnt); end
        rst = 1'b1;
        #1;
        checks++;
        if (do_vld !== 1'b0 || do_bit !== 1'b0 || do_last !== 1'b0) begin
            failures++; $display("[TB] FAIL rst_outputs_drop vld=%b bit=%b last=%b want=000", do_vld, do_bit, do_last);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (di_rdy !== 1'b1) begin failures++; $display("[TB] FAIL rst_rdy_after got=%b want=1", di_rdy); end
        @(negedge clk);
        clearMon();
        runImpulse();
        got = '0;
        for (int i = 0; i < 14 && i < outBits.size(); i++) got[13-i] = outBits[i];
        checks++;
        if (outBits.size() != 14 || got !== 14'b11_01_11_11_00_10_11) begin
            failures++; $display("[TB] FAIL rst_repeat_impulse got=%b count=%0d want=11011111001011 count=14", got, outBits.size());
        end
    endtask

`ifdef CONV_PUNCTURE_EN
    task automatic test_puncture();
        logic [9:0] got;
        int rh;
        bit seen;
        got = '0;
        clearMon();
        rate_sel = 1'b1;
        frameBits[0] = 1'b1;
        sendFrame(1, 1'b0);
        rate_sel = 1'b0;
        waitFrameEnd(rh, seen);
        for (int i = 0; i < 10 && i < outBits.size(); i++) got[9-i] = outBits[i];
        checks++;
        if (outBits.size() != 10) begin failures++; $display("[TB] FAIL punct_count got=%0d want=10", outBits.size()); end
        checks++;
        if (got !== 10'b1101110011) begin failures++; $display("[TB] FAIL punct_stream got=%b want=1101110011", got); end
        checks++;
        if (outBits.size() == 10 && outLast[9] !== 1'b1) begin
            failures++; $display("[TB] FAIL punct_last got=%b want=1", outLast[9]);
        end
    endtask
`endif

    initial begin
        rst     = 1'b1;
        di_bit  = 1'b0;
        di_vld  = 1'b0;
        di_last = 1'b0;
`ifdef CONV_PUNCTURE_EN
        rate_sel = 1'b0;
`endif
        test_reset();
        test_impulse();
        test_all_zero();
        test_back_to_back();
        test_stall();
        test_reset_mid_tail();
`ifdef CONV_PUNCTURE_EN
        test_puncture();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
